// File: rtl/systolic_result_writer.sv
// Snapshots the systolic array result tile on start and writes the valid
// sub-tile back to memory row-major in WRITE_BW-word beats.
module systolic_result_writer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int WRITE_BW   = 4,
    parameter int TILE       = 8,
    parameter int DIM_WIDTH  = 6
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] Out,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [DIM_WIDTH-1:0]                      dim_rows,
    input  logic [DIM_WIDTH-1:0]                      dim_cols,
    input  logic [DIM_WIDTH-1:0]                      stride,
    output logic                                      write,
    output logic [ADDR_WIDTH-1:0]                     write_addr,
    output logic [WRITE_BW*DATA_WIDTH-1:0]            writedata,
    output logic [WRITE_BW-1:0]                       write_mask,
    input  logic                                      write_ready,
    output logic                                      busy,
    output logic                                      done
);

    localparam int CW    = $clog2(TILE + 1);
    localparam int RW    = $clog2(TILE);
    localparam int BEATS = (TILE + WRITE_BW - 1) / WRITE_BW;
    localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = DIM_WIDTH + RW;
    localparam int SW    = ADDR_WIDTH + PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t state, state_nx;

    logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] snap;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DIM_WIDTH-1:0]  stride_q;
    logic [CW-1:0]         rows_q, cols_q, rows_c, cols_c;
    logic [RW-1:0]         r_q;
    logic [BTW-1:0]        beat_q, last_beat;
    logic                  capture, accept, row_end, last_row;
    logic [PW-1:0]         row_off;
    logic [SW-1:0]         addr_sum;
    logic [31:0]           col;

    assign rows_c = (dim_rows > DIM_WIDTH'(TILE)) ? CW'(TILE) : CW'(dim_rows);
    assign cols_c = (dim_cols > DIM_WIDTH'(TILE)) ? CW'(TILE) : CW'(dim_cols);

    assign capture   = (state == S_IDLE) && start;
    assign accept    = write && write_ready;
    assign last_beat = BTW'((cols_q - CW'(1)) / CW'(WRITE_BW));
    assign row_end   = (beat_q == last_beat);
    assign last_row  = (CW'(r_q) == rows_q - CW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nx = (rows_c == '0 || cols_c == '0) ? S_FINISH : S_WRITE;
            end
            S_WRITE: begin
                if (accept && row_end && last_row)
                    state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            r_q      <= '0;
            beat_q   <= '0;
        end else if (capture) begin
            base_q   <= base_addr;
            stride_q <= stride;
            rows_q   <= rows_c;
            cols_q   <= cols_c;
            r_q      <= '0;
            beat_q   <= '0;
        end else if (accept) begin
            if (row_end) begin
                beat_q <= '0;
                r_q    <= r_q + RW'(1);
            end else begin
                beat_q <= beat_q + BTW'(1);
            end
        end
    end

    // Snapshot contents are don't-care after reset, so no reset on this array.
    always_ff @(posedge clock) begin
        if (capture) snap <= Out;
    end

    always_comb begin
        write      = 1'b0;
        busy       = 1'b0;
        done       = (state == S_FINISH);
        write_addr = '0;
        writedata  = '0;
        write_mask = '0;
        row_off    = '0;
        addr_sum   = '0;
        col        = '0;
        if (state == S_WRITE) begin
            write      = 1'b1;
            busy       = 1'b1;
            row_off    = PW'(r_q) * PW'(stride_q);
            addr_sum   = SW'(base_q) + SW'(row_off) + SW'(beat_q) * SW'(WRITE_BW);
            write_addr = addr_sum[ADDR_WIDTH-1:0];
            for (int k = 0; k < WRITE_BW; k++) begin
                col = 32'(beat_q) * WRITE_BW + k;
                writedata[k*DATA_WIDTH +: DATA_WIDTH] = snap[r_q][col[RW-1:0]];
                write_mask[k] = (col < 32'(cols_q));
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_writer.sv
// Randomized bench for systolic_result_writer against a queue-based
// model of the expected beat sequence.
module tb_systolic_result_writer;

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic [7:0][7:0][31:0]   out_v;
    logic [11:0]             base_addr = '0;
    logic [5:0]              dim_rows = '0;
    logic [5:0]              dim_cols = '0;
    logic [5:0]              stride = '0;
    logic                    write;
    logic [11:0]             write_addr;
    logic [127:0]            writedata;
    logic [3:0]              write_mask;
    logic                    write_ready = 1'b0;
    logic                    busy;
    logic                    done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0]  e_addr[$];
    logic [127:0] e_data[$];
    logic [3:0]   e_mask[$];

    always #5 clock = ~clock;

    systolic_result_writer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .Out(out_v),
        .base_addr(base_addr), .dim_rows(dim_rows), .dim_cols(dim_cols),
        .stride(stride), .write(write), .write_addr(write_addr),
        .writedata(writedata), .write_mask(write_mask),
        .write_ready(write_ready), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) out_v[r][c] = 32'(8 * r + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) out_v[r][c] = $urandom;
    endtask

    function automatic logic [127:0] lane_bits(input logic [3:0] m);
        logic [127:0] v = '0;
        for (int k = 0; k < 4; k++) if (m[k]) v[k*32 +: 32] = '1;
        return v;
    endfunction

    // Expected beats: every row of the clamped tile, cols split into 4-word groups.
    task automatic build_model(input int dr, input int dc, input int st,
                               input int ba);
        int rows, cols, c;
        logic [127:0] d;
        logic [3:0] m;
        rows = (dr > 8) ? 8 : dr;
        cols = (dc > 8) ? 8 : dc;
        e_addr.delete(); e_data.delete(); e_mask.delete();
        if (rows == 0 || cols == 0) return;
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; 4 * b < cols; b++) begin
                d = '0; m = '0;
                for (int k = 0; k < 4; k++) begin
                    c = 4 * b + k;
                    if (c < cols) begin
                        m[k] = 1'b1;
                        d[k*32 +: 32] = out_v[r][c];
                    end
                end
                e_addr.push_back(12'((ba + r * st + 4 * b) % 4096));
                e_data.push_back(d);
                e_mask.push_back(m);
            end
        end
    endtask

    task automatic run_op(input string tag, input int dr, input int dc,
                          input int st, input int ba, input int stall_beat,
                          input int stall_len, input bit rnd_ready,
                          input bit restart, input int exp_done);
        int idx, stalled, last_acc;
        bit fin;
        @(negedge clock);
        dim_rows = 6'(dr); dim_cols = 6'(dc); stride = 6'(st);
        base_addr = 12'(ba); start = 1'b1; write_ready = 1'b1;
        build_model(dr, dc, st, ba);
        @(posedge clock); #1;
        start = 1'b0;
        fill_rand();
        base_addr = 12'($urandom); dim_rows = 6'($urandom); stride = 6'($urandom);
        idx = 0; stalled = 0; last_acc = 0; fin = 1'b0;
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            write_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (idx == stall_beat && stalled < stall_len) begin
                write_ready = 1'b0;
                stalled++;
            end
            start = (restart && cyc == 2);
            if (done) begin
                fin = 1'b1;
                check({tag, " done_cycle"}, 128'(cyc), 128'(last_acc + 1));
                if (exp_done > 0)
                    check({tag, " done_abs"}, 128'(cyc), 128'(exp_done));
                check({tag, " beats"}, 128'(idx), 128'(e_addr.size()));
                check({tag, " busy_fin"}, busy, 1'b0);
                check({tag, " write_fin"}, write, 1'b0);
            end else begin
                check({tag, " busy"}, busy, 1'b1);
                check({tag, " write"}, write, 1'b1);
                check({tag, " in_range"}, (idx < e_addr.size()), 1'b1);
                if (write && idx < e_addr.size()) begin
                    check({tag, " addr"}, write_addr, e_addr[idx]);
                    check({tag, " mask"}, write_mask, e_mask[idx]);
                    check({tag, " data"}, writedata & lane_bits(e_mask[idx]),
                          e_data[idx]);
                    if (write_ready) begin
                        idx++;
                        last_acc = cyc;
                    end
                end
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        if (!fin) check({tag, " timeout"}, 1'b0, 1'b1);
        else begin
            check({tag, " done_pulse"}, done, 1'b0);
            check({tag, " write_idle"}, write, 1'b0);
        end
        write_ready = 1'b0;
    endtask

    initial begin
        fill_ramp();
        #23;
        check("rst write", write, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst mask", write_mask, 4'b0);
        check("rst addr", write_addr, 12'd0);
        check("rst data", writedata, 128'd0);
        @(negedge clock);
        reset_n = 1'b1;

        fill_ramp();
        run_op("full", 8, 8, 8, 140, -1, 0, 1'b0, 1'b0, 17);
        fill_ramp();
        run_op("bp", 8, 8, 8, 140, 5, 3, 1'b0, 1'b0, 20);
        fill_ramp();
        run_op("part", 3, 5, 10, 0, -1, 0, 1'b0, 1'b0, 7);
        run_op("empty_r", 0, 8, 8, 12, -1, 0, 1'b0, 1'b0, 1);
        run_op("empty_c", 5, 0, 8, 12, -1, 0, 1'b0, 1'b0, 1);
        fill_rand();
        run_op("oversize", 8, 20, 8, 300, -1, 0, 1'b0, 1'b0, 17);
        fill_rand();
        run_op("wrap", 1, 8, 8, 4092, -1, 0, 1'b0, 1'b1, 3);

        // Asynchronous abort while beat 4 is on the bus.
        fill_ramp();
        @(negedge clock);
        dim_rows = 6'd8; dim_cols = 6'd8; stride = 6'd8; base_addr = '0;
        start = 1'b1; write_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        check("rst_mid pre", write, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid write", write, 1'b0);
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid done", done, 1'b0);
        @(posedge clock); #1;
        check("rst_mid done2", done, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        write_ready = 1'b0;
        fill_ramp();
        run_op("after_rst", 8, 8, 8, 140, -1, 0, 1'b0, 1'b0, 17);

        for (int i = 0; i < 25; i++) begin
            fill_rand();
            run_op("rand", $urandom_range(0, 10), $urandom_range(0, 10),
                   $urandom_range(0, 63), $urandom_range(0, 4095),
                   -1, 0, 1'b1, ($urandom_range(0, 1) == 1), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
